// File: rtl/cva6_mem_ar_arbiter.sv
// cva6_mem_ar_arbiter: round-robin AXI4 AR arbiter with per-requester outstanding limits and R routing by RID
// Ports: clk_i/rst_ni clock and async active-low reset;
//   s_ar* requester AR channels (packed, requester k at slice k); s_r* routed R channel;
//   m_ar* master AR channel with ARID = {requester index, requester ID};
//   m_r* master R channel; err_o sticky protocol-error flag.
module cva6_mem_ar_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTSTANDING = 7,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int MID_W = ID_WIDTH + IDX_W,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            s_arvalid_i,
  output logic [NUM_REQ-1:0]            s_arready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   s_arid_i,
  input  logic [NUM_REQ*8-1:0]          s_arlen_i,
  output logic [NUM_REQ-1:0]            s_rvalid_o,
  input  logic [NUM_REQ-1:0]            s_rready_i,
  output logic [ID_WIDTH-1:0]           s_rid_o,
  output logic [DATA_WIDTH-1:0]         s_rdata_o,
  output logic                          s_rlast_o,
  output logic                          m_arvalid_o,
  input  logic                          m_arready_i,
  output logic [ADDR_WIDTH-1:0]         m_araddr_o,
  output logic [MID_W-1:0]              m_arid_o,
  output logic [7:0]                    m_arlen_o,
  input  logic                          m_rvalid_i,
  output logic                          m_rready_o,
  input  logic [MID_W-1:0]              m_rid_i,
  input  logic [DATA_WIDTH-1:0]         m_rdata_i,
  input  logic                          m_rlast_i,
  output logic                          err_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, win, ridx;
  logic [NUM_REQ-1:0] elig, zero, inc, dec;
  logic found, hs, rbad, rdone;
  logic [CW-1:0] cnt [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = s_arvalid_i[k] && cnt[k] < CW'(MAX_OUTSTANDING);
      zero[k] = cnt[k] == '0;
    end
  end

  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;

  always_comb state_n = state == IDLE ? (found ? BUSY : IDLE) : (m_arready_i ? IDLE : BUSY);

  // an eligible requester is always valid, so a grant is always a handshake
  always_comb begin
    hs = state == IDLE && found;
    s_arready_o = hs ? NUM_REQ'(1) << win : '0;
    m_arvalid_o = state == BUSY;
  end

  always_comb begin
    ridx = m_rid_i[MID_W-1 -: IDX_W];
    rbad = int'(ridx) >= NUM_REQ;
    s_rvalid_o = rbad ? '0 : NUM_REQ'(m_rvalid_i) << ridx;
    m_rready_o = rbad || |(s_rready_i & (NUM_REQ'(1) << ridx));
    s_rid_o = m_rid_i[ID_WIDTH-1:0];
    s_rdata_o = m_rdata_i;
    s_rlast_o = m_rlast_i;
    rdone = m_rvalid_i && m_rready_o && m_rlast_i && !rbad;
    inc = hs ? NUM_REQ'(1) << win : '0;
    dec = rdone ? NUM_REQ'(1) << ridx : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
      m_araddr_o <= '0;
      m_arid_o <= '0;
      m_arlen_o <= '0;
      err_o <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
    end else begin
      if (hs) begin
        ptr <= int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
        m_araddr_o <= s_araddr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        m_arid_o <= {win, s_arid_i[win*ID_WIDTH +: ID_WIDTH]};
        m_arlen_o <= s_arlen_i[win*8 +: 8];
      end
      if ((m_rvalid_i && rbad) || |(dec & zero)) err_o <= 1'b1;
      // a last beat with nothing outstanding is flagged and leaves the counter at zero
      for (int k = 0; k < NUM_REQ; k++)
        if (inc[k] && !dec[k]) cnt[k] <= cnt[k] + 1'b1;
        else if (dec[k] && !inc[k] && !zero[k]) cnt[k] <= cnt[k] - 1'b1;
    end
  end
endmodule
